uart_rx: RTL and testbench

//  Oversampled UART receiver; counterpart to the UART TX block. Synchronises the async rx pin,

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_parity.sv | 13 +
 rtl/uart_rx.sv | 197 +++++++++++++++++++
 tb/tb_uart_rx.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions.
//  uart_state_e   : receiver/transmitter frame states
//  parity_mode_e  : decoded parity setting used by the UART blocks
package uart_pkg;

  typedef enum logic [2:0] {
    UART_IDLE,
    UART_START,
    UART_DATA,
    UART_PARITY,
    UART_STOP
  } uart_state_e;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_mode_e;

endpackage

// File: rtl/uart_parity.sv
// XOR-reduction parity of a data word, shared by the UART TX and RX blocks.
//  data_i   : word to reduce
//  parity_o : XOR of all bits of data_i (1 when the count of ones is odd)
module uart_parity #(
  parameter int BITS = 8
) (
  input  logic [BITS-1:0] data_i,
  output logic            parity_o
);

  assign parity_o = ^data_i;

endmodule

// File: rtl/uart_rx.sv
// Oversampled UART receiver with a one-entry valid/ready output register.
//  clk        : OVERSAMPLE x baud clock
//  rst        : synchronous, active-high reset
//  rx         : asynchronous serial line, idle high
//  rx_data    : received word, stable while valid
//  valid      : rx_data and the flags hold a frame
//  ready      : consumer accepts; handshake = valid & ready
//  parity_err : parity mismatch in the held frame
//  frame_err  : a stop bit was sampled low in the held frame
//  overrun    : at least one later frame was dropped while this one was held
module uart_rx
  import uart_pkg::*;
#(
  parameter int    DATA_BITS  = 8,
  parameter string PARITY_BIT = "none",
  parameter int    STOP_BITS  = 1,
  parameter int    OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam parity_mode_e PMODE = (PARITY_BIT == "even") ? PAR_EVEN :
                                   (PARITY_BIT == "odd")  ? PAR_ODD  : PAR_NONE;
  localparam int SCW = $clog2(OVERSAMPLE);
  localparam int BCW = $clog2(DATA_BITS);

  localparam logic [SCW-1:0] HALF_M1   = SCW'(OVERSAMPLE / 2 - 1);
  localparam logic [SCW-1:0] FULL_M1   = SCW'(OVERSAMPLE - 1);
  localparam logic [BCW-1:0] LAST_BIT  = BCW'(DATA_BITS - 1);
  localparam logic           LAST_STOP = 1'(STOP_BITS - 1);

  // ---------------------------------------------------------------- sync
  logic sync1_q, sync2_q, rx_s;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of the others (the two sync stages rely on it).
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= rx;
      sync2_q <= sync1_q;
    end
  end

  assign rx_s = sync2_q;

  // ---------------------------------------------------------------- FSM
  uart_state_e    state_q, state_d;
  logic [SCW-1:0] samp_cnt_q;
  logic [BCW-1:0] bit_cnt_q;
  logic           stop_cnt_q;
  logic           tick, last_stop;
  logic           load_half, shift_en, par_en, stop_en, frame_done;

  // tick marks a mid-bit sample instant while a frame is in progress.
  assign tick      = (samp_cnt_q == '0);
  assign last_stop = (stop_cnt_q == LAST_STOP);

  always_ff @(posedge clk) begin
    if (rst) state_q <= UART_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      UART_IDLE:   if (!rx_s) state_d = UART_START;
      UART_START:  if (tick)  state_d = rx_s ? UART_IDLE : UART_DATA;
      UART_DATA:   if (tick && bit_cnt_q == LAST_BIT)
                     state_d = (PMODE != PAR_NONE) ? UART_PARITY : UART_STOP;
      UART_PARITY: if (tick)  state_d = UART_STOP;
      UART_STOP:   if (tick && last_stop) state_d = UART_IDLE;
      default:     state_d = UART_IDLE;
    endcase
  end

  always_comb begin
    load_half  = 1'b0;
    shift_en   = 1'b0;
    par_en     = 1'b0;
    stop_en    = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      UART_IDLE:   load_half = !rx_s;
      UART_DATA:   shift_en  = tick;
      UART_PARITY: par_en    = tick;
      UART_STOP: begin
        stop_en    = tick;
        frame_done = tick && last_stop;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------- counters
  // The first sample lands half a bit after the falling edge; every later
  // sample is one full bit period after the previous one.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_cnt_q <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
    end else begin
      if (load_half)
        samp_cnt_q <= HALF_M1;
      else if (state_q != UART_IDLE)
        samp_cnt_q <= tick ? FULL_M1 : samp_cnt_q - SCW'(1);

      if (state_q == UART_START)
        bit_cnt_q <= '0;
      else if (shift_en && bit_cnt_q != LAST_BIT)
        bit_cnt_q <= bit_cnt_q + BCW'(1);

      if (state_q == UART_START)
        stop_cnt_q <= 1'b0;
      else if (stop_en && !last_stop)
        stop_cnt_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- datapath
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q, frm_err_q, data_par;

  uart_parity #(.BITS(DATA_BITS)) u_parity (
    .data_i   (shift_q),
    .parity_o (data_par)
  );

  // Bits arrive LSB first and shift in from the top, so after DATA_BITS
  // shifts bit k sits at position k.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q   <= '0;
      par_err_q <= 1'b0;
      frm_err_q <= 1'b0;
    end else begin
      if (shift_en) shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
      if (state_q == UART_START) begin
        par_err_q <= 1'b0;
        frm_err_q <= 1'b0;
      end
      // Even expects data^bit == 0, odd expects 1.
      if (par_en)             par_err_q <= data_par ^ rx_s ^ (PMODE == PAR_ODD);
      if (stop_en && !rx_s)   frm_err_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- output register
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 valid_q, perr_q, ferr_q, ovr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_q <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else if (frame_done) begin
      if (!valid_q || ready) begin
        // The final stop sample is folded in here since it is still in rx_s.
        rx_data_q <= shift_q;
        perr_q    <= par_err_q;
        ferr_q    <= frm_err_q | !rx_s;
        valid_q   <= 1'b1;
        ovr_q     <= 1'b0;
      end else begin
        ovr_q     <= 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end
  end

  assign rx_data    = rx_data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: an 8N1 and an 8E2 instance, both OVERSAMPLE=16.
// Each frame is built as a per-clock line waveform; the reference model
// decodes it by reading the line at the mid-bit instants (half a bit after
// the falling edge, then every OVERSAMPLE clocks) and queues the expected
// word and flags. Monitors pop and compare on every valid&ready handshake.
module tb_uart_rx;

  localparam int OS = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       rx_n, ready_n, valid_n, perr_n, ferr_n, ovr_n;
  logic [7:0] data_n;
  logic       rx_e, ready_e, valid_e, perr_e, ferr_e, ovr_e;
  logic [7:0] data_e;

  uart_rx #(.DATA_BITS(8), .PARITY_BIT("none"), .STOP_BITS(1), .OVERSAMPLE(OS)) u_dut_n (
    .clk(clk), .rst(rst), .rx(rx_n), .rx_data(data_n), .valid(valid_n), .ready(ready_n),
    .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_n)
  );

  uart_rx #(.DATA_BITS(8), .PARITY_BIT("even"), .STOP_BITS(2), .OVERSAMPLE(OS)) u_dut_e (
    .clk(clk), .rst(rst), .rx(rx_e), .rx_data(data_e), .valid(valid_e), .ready(ready_e),
    .parity_err(perr_e), .frame_err(ferr_e), .overrun(ovr_e)
  );

  typedef struct {
    logic [7:0] data;
    logic       perr;
    logic       ferr;
    logic       ovr;
    int         exp_cyc;   // -1: delivery time not checked
  } exp_t;

  exp_t q_n[$];
  exp_t q_e[$];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: unexpected event (t=%0t)", name, $time);
  endtask

  // ---------------------------------------------------------------- monitors
  always @(negedge clk) begin : mon_n
    exp_t e;
    #1;
    if (valid_n && ready_n) begin
      if (q_n.size() == 0) fail_now("n_spurious_valid");
      else begin
        e = q_n.pop_front();
        check("n_data", data_n, e.data);
        check("n_parity_err", perr_n, e.perr);
        check("n_frame_err", ferr_n, e.ferr);
        check("n_overrun", ovr_n, e.ovr);
        if (e.exp_cyc >= 0) check("n_latency", cyc, e.exp_cyc);
      end
    end
  end

  always @(negedge clk) begin : mon_e
    exp_t e;
    #1;
    if (valid_e && ready_e) begin
      if (q_e.size() == 0) fail_now("e_spurious_valid");
      else begin
        e = q_e.pop_front();
        check("e_data", data_e, e.data);
        check("e_parity_err", perr_e, e.perr);
        check("e_frame_err", ferr_e, e.ferr);
        check("e_overrun", ovr_e, e.ovr);
        if (e.exp_cyc >= 0) check("e_latency", cyc, e.exp_cyc);
      end
    end
  end

  // ---------------------------------------------------------------- stimulus + model
  // which: 0 = 8N1 instance, 1 = 8E2 instance. stop_low holds the first
  // stop bit low for that many clocks. period is the sender's bit length.
  task automatic send_frame(input int which, input logic [7:0] data, input logic par_bit,
                            input int period, input int stop_low,
                            input bit push, input bit ovr, input bit timed);
    bit   wave[$];
    bit   samp[$];
    int   has_par, n_stop, nb, idx, c0;
    exp_t e;
    logic [7:0] d;
    logic ferr;

    has_par = (which == 1) ? 1 : 0;
    n_stop  = (which == 1) ? 2 : 1;
    nb      = 1 + 8 + has_par + n_stop;

    repeat (period) wave.push_back(1'b0);
    for (int k = 0; k < 8; k++) repeat (period) wave.push_back(data[k]);
    if (has_par == 1) repeat (period) wave.push_back(par_bit);
    for (int s = 0; s < n_stop; s++)
      for (int i = 0; i < period; i++)
        wave.push_back((s == 0 && i < stop_low) ? 1'b0 : 1'b1);

    // Mid-bit sampling of the line as transmitted; idle high beyond the end.
    for (int j = 0; j < nb; j++) begin
      idx = OS / 2 + j * OS;
      samp.push_back((idx < wave.size()) ? wave[idx] : 1'b1);
    end
    for (int k = 0; k < 8; k++) d[k] = samp[k + 1];
    ferr = 1'b0;
    for (int s = 0; s < n_stop; s++) if (samp[9 + has_par + s] == 1'b0) ferr = 1'b1;

    @(negedge clk);
    c0 = cyc;
    e.data    = d;
    e.perr    = (has_par == 1) ? ((^d) ^ samp[9]) : 1'b0;
    e.ferr    = ferr;
    e.ovr     = ovr;
    // Two synchroniser clocks, then the last stop sample, then one clock to load.
    e.exp_cyc = timed ? (c0 + 2 + OS / 2 + (nb - 1) * OS + 1) : -1;
    if (push) begin
      if (which == 0) q_n.push_back(e);
      else            q_e.push_back(e);
    end

    for (int i = 0; i < wave.size(); i++) begin
      if (i > 0) @(negedge clk);
      if (which == 0) rx_n = wave[i];
      else            rx_e = wave[i];
    end
    @(negedge clk);
    if (which == 0) rx_n = 1'b1;
    else            rx_e = 1'b1;
    repeat (2 * OS) @(negedge clk);
  endtask

  task automatic wait_drain(input int which);
    int left;
    left = 400;
    while (left > 0 && ((which == 0) ? q_n.size() : q_e.size()) != 0) begin
      @(negedge clk);
      left--;
    end
    if (which == 0) check("n_drain", q_n.size(), 0);
    else            check("e_drain", q_e.size(), 0);
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [7:0] v;
    rst = 1'b1;
    rx_n = 1'b1; rx_e = 1'b1;
    ready_n = 1'b1; ready_e = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_valid_n", valid_n, 1'b0);
    check("rst_data_n", data_n, 8'h00);
    check("rst_flags_n", {perr_n, ferr_n, ovr_n}, 3'b000);
    check("rst_valid_e", valid_e, 1'b0);
    check("rst_flags_e", {perr_e, ferr_e, ovr_e}, 3'b000);

    // 8N1 basic frame with delivery latency
    send_frame(0, 8'h55, 1'b0, OS, 0, 1, 0, 1);
    wait_drain(0);

    // 8E2: correct even parity bit, then wrong one
    send_frame(1, 8'hA5, 1'b0, OS, 0, 1, 0, 1);
    wait_drain(1);
    send_frame(1, 8'hA5, 1'b1, OS, 0, 1, 0, 1);
    wait_drain(1);

    // Stop bit low past its mid-bit sample, then a clean frame
    send_frame(0, 8'h3C, 1'b0, OS, OS / 2 + 1, 1, 0, 1);
    wait_drain(0);
    send_frame(0, 8'h01, 1'b0, OS, 0, 1, 0, 1);
    wait_drain(0);

    // Short low glitch must not start a frame
    @(negedge clk);
    rx_n = 1'b0;
    repeat (4) @(negedge clk);
    rx_n = 1'b1;
    repeat (3 * OS) @(negedge clk);
    #1;
    check("glitch_no_valid", valid_n, 1'b0);
    send_frame(0, 8'hF0, 1'b0, OS, 0, 1, 0, 1);
    wait_drain(0);

    // Overrun: consumer stalled across two frames
    ready_n = 1'b0;
    send_frame(0, 8'h11, 1'b0, OS, 0, 1, 1, 0);
    send_frame(0, 8'h22, 1'b0, OS, 0, 0, 0, 0);
    #1;
    check("ovr_valid_held", valid_n, 1'b1);
    check("ovr_data_kept", data_n, 8'h11);
    check("ovr_flag", ovr_n, 1'b1);
    @(negedge clk);
    ready_n = 1'b1;
    @(negedge clk);
    ready_n = 1'b0;
    #1;
    check("ovr_cleared_valid", valid_n, 1'b0);
    check("ovr_cleared_flag", ovr_n, 1'b0);
    wait_drain(0);
    ready_n = 1'b1;

    // Reset in the middle of the data bits of 0x77
    v = 8'h77;
    for (int i = 0; i < 4 * OS; i++) begin
      @(negedge clk);
      rx_n = (i < OS) ? 1'b0 : v[i / OS - 1];
    end
    @(negedge clk);
    rst = 1'b1;
    rx_n = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12 * OS) @(negedge clk);
    #1;
    check("abandon_no_valid", valid_n, 1'b0);
    send_frame(0, 8'h42, 1'b0, OS, 0, 1, 0, 1);
    wait_drain(0);

    // Randomised frames on both instances
    for (int r = 0; r < 6; r++) begin
      send_frame(0, 8'($urandom), 1'b0, OS, 0, 1, 0, 1);
      send_frame(1, 8'($urandom), 1'($urandom), OS, 0, 1, 0, 1);
    end
    wait_drain(0);
    wait_drain(1);

    // Sender bit periods of 15 and 17 clocks. Mid-bit sampling drifts one
    // clock per bit; at 17 the final stop sample lands on the last clock of
    // data bit 7, and the model predicts the outcome from the same rule.
    send_frame(0, 8'h5A, 1'b0, OS - 1, 0, 1, 0, 1);
    wait_drain(0);
    send_frame(0, 8'h5A, 1'b0, OS + 1, 0, 1, 0, 1);
    wait_drain(0);

    repeat (4 * OS) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
